// File: rtl/fm_pkg.sv
// Shared types and the per-sample phase increment for the FM modulator.
package fm_pkg;
    localparam int PHASE_W  = 32;
    localparam int ANGLE_W  = 16;
    localparam int SAMPLE_W = 16;

    typedef logic [PHASE_W-1:0]         phase_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Sign-extend the sample to full phase width before scaling; the sum wraps mod 2^32.
    function automatic phase_t phase_inc(input sample_t sample, input phase_t carrier,
                                         input int unsigned shift);
        logic signed [PHASE_W-1:0] sext;
        sext = PHASE_W'(sample);
        return carrier + phase_t'(sext <<< shift);
    endfunction
endpackage

// File: rtl/fm_phase_acc.sv
// Stage-2 phase integrator: presents acc + inc and commits it on valid enabled beats.
module fm_phase_acc
    import fm_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   vld,
    input  phase_t inc,
    input  logic   clr_after,
    output phase_t acc_n
);
    phase_t acc_p2;

    assign acc_n = acc_p2 + inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2 <= '0;
        end else if (en && vld) begin
            acc_p2 <= clr_after ? '0 : acc_n;
        end
    end
endmodule

// File: rtl/fm_modulate.sv
// Streaming FM modulator: audio samples in, polar words {angle, magnitude} out, 2-cycle latency.
module fm_modulate
    import fm_pkg::*;
#(
    parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
    parameter logic [31:0] CARRIER_INC            = 32'h0400_0000,
    parameter int          DEV_SHIFT              = 12,
    parameter logic [15:0] AMPLITUDE              = 16'h7FFF,
    parameter bit          PHASE_RST_ON_LAST      = 1'b0
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);
    localparam int unsigned SHIFT = DEV_SHIFT;

    logic    en;
    sample_t sample_in;
    logic    unused_hi;

    assign en              = !m00_axis_tvalid || m00_axis_tready;
    assign s00_axis_tready = en;
    assign sample_in       = sample_t'(s00_axis_tdata[SAMPLE_W-1:0]);
    assign unused_hi       = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:SAMPLE_W];

    // Stage 1: scale sample into a phase increment
    logic                                  vld_p1;
    phase_t                                inc_p1;
    logic                                  last_p1;
    logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] strb_p1;

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= s00_axis_tvalid;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (en && s00_axis_tvalid) begin
            inc_p1  <= phase_inc(sample_in, CARRIER_INC, SHIFT);
            last_p1 <= s00_axis_tlast;
            strb_p1 <= s00_axis_tstrb;
        end
    end

    // Stage 2: integrate phase and register the output word
    phase_t acc_n;

    fm_phase_acc u_phase_acc (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .en        (en),
        .vld       (vld_p1),
        .inc       (inc_p1),
        .clr_after (PHASE_RST_ON_LAST && last_p1),
        .acc_n     (acc_n)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
        end else if (en) begin
            m00_axis_tvalid <= vld_p1;
            if (vld_p1) begin
                m00_axis_tdata <= C_M00_AXIS_TDATA_WIDTH'({acc_n[PHASE_W-1 -: ANGLE_W], AMPLITUDE});
                m00_axis_tstrb <= (C_M00_AXIS_TDATA_WIDTH/8)'(strb_p1);
                m00_axis_tlast <= last_p1;
            end
        end
    end
endmodule
